capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_pkg.sv | 26 ++
 rtl/capture_ring_cnt.sv | 28 ++
 rtl/capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_capture_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the capture controller and its index counter.
package capture_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 32;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } cap_state_t;

   // Pre-trigger count may never reach the depth: at least the trigger sample must fit.
   function automatic logic [CNT_W-1:0] clamp_pos(input logic [CNT_W-1:0] depth,
                                                  input logic [CNT_W-1:0] pos);
      if (pos >= depth) begin
         return depth - CNT_ONE;
      end
      return pos;
   endfunction

endpackage

// File: rtl/capture_ring_cnt.sv
// Ring-buffer write index: counts forwarded samples modulo the capture depth.
module ring_cnt
   import capture_pkg::*;
(
   input  logic             core_clk,
   input  logic             core_rst,
   input  logic             clear,
   input  logic             inc,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] index
);

   logic [CNT_W-1:0] index_reg;

   // Compare against the last index instead of incrementing first, so no 32-bit overflow.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         index_reg <= '0;
      end else if (clear) begin
         index_reg <= '0;
      end else if (inc) begin
         index_reg <= (index_reg == last) ? '0 : index_reg + CNT_ONE;
      end
   end

   assign index = index_reg;

endmodule

// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture sequencer: forwards sampler data to the ring-buffer writer.
module capture_ctrl
   import capture_pkg::*;
(
   input  logic              core_clk,
   input  logic              core_rst,
   input  logic              sample_en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              trigger_hit,
   input  logic [CNT_W-1:0]  sample_depth,
   input  logic [CNT_W-1:0]  trigger_pos,
   output logic              capture_valid,
   output logic [DATA_W-1:0] capture_data,
   output logic              capture_done,
   output logic [CNT_W-1:0]  sample_last_cnt,
   output logic              trig_valid,
   output logic [CNT_W-1:0]  trig_index
);

   cap_state_t        state_reg, state_next;
   logic              sample_en_reg;
   logic [CNT_W-1:0]  pos_reg, pos_next;
   logic [CNT_W-1:0]  post_len_reg, post_len_next;
   logic [CNT_W-1:0]  last_cnt_reg, last_cnt_next;
   logic [CNT_W-1:0]  pre_cnt_reg, pre_cnt_next;
   logic [CNT_W-1:0]  post_cnt_reg, post_cnt_next;
   logic              trig_valid_reg, trig_valid_next;
   logic [CNT_W-1:0]  trig_index_reg, trig_index_next;
   logic              capture_valid_reg;
   logic [DATA_W-1:0] capture_data_reg;

   logic              en_rise;
   logic              start;
   logic              fwd;
   logic [CNT_W-1:0]  depth_eff;
   logic [CNT_W-1:0]  pos_clamped;
   logic [CNT_W-1:0]  pre_cnt_inc;
   logic [CNT_W-1:0]  post_cnt_inc;
   logic [CNT_W-1:0]  wr_index;

   assign en_rise      = sample_en & ~sample_en_reg;
   assign depth_eff    = (sample_depth == '0) ? CNT_ONE : sample_depth;
   assign pos_clamped  = clamp_pos(depth_eff, trigger_pos);
   assign pre_cnt_inc  = pre_cnt_reg + CNT_ONE;
   assign post_cnt_inc = post_cnt_reg + CNT_ONE;

   ring_cnt u_ring_cnt (
      .core_clk (core_clk),
      .core_rst (core_rst),
      .clear    (start),
      .inc      (fwd),
      .last     (last_cnt_reg),
      .index    (wr_index)
   );

   always_comb begin
      state_next      = state_reg;
      pos_next        = pos_reg;
      post_len_next   = post_len_reg;
      last_cnt_next   = last_cnt_reg;
      pre_cnt_next    = pre_cnt_reg;
      post_cnt_next   = post_cnt_reg;
      trig_valid_next = trig_valid_reg;
      trig_index_next = trig_index_reg;
      start           = 1'b0;
      fwd             = 1'b0;

      case (state_reg)
         IDLE: begin
            if (en_rise) begin
               start           = 1'b1;
               pos_next        = pos_clamped;
               post_len_next   = depth_eff - pos_clamped;
               last_cnt_next   = depth_eff - CNT_ONE;
               pre_cnt_next    = '0;
               post_cnt_next   = '0;
               trig_valid_next = 1'b0;
               state_next      = (pos_clamped == '0) ? WAIT_TRIG : PRE;
            end
         end
         PRE: begin
            if (!sample_en) begin
               state_next = DONE;
            end else if (sample_valid) begin
               fwd          = 1'b1;
               pre_cnt_next = pre_cnt_inc;
               if (pre_cnt_inc == pos_reg) begin
                  state_next = WAIT_TRIG;
               end
            end
         end
         WAIT_TRIG: begin
            if (!sample_en) begin
               state_next = DONE;
            end else if (sample_valid) begin
               fwd = 1'b1;
               if (trigger_hit) begin
                  trig_index_next = wr_index;
                  trig_valid_next = 1'b1;
                  post_cnt_next   = CNT_ONE;
                  state_next      = (post_len_reg == CNT_ONE) ? DONE : POST;
               end
            end
         end
         POST: begin
            if (!sample_en) begin
               state_next = DONE;
            end else if (sample_valid) begin
               fwd           = 1'b1;
               post_cnt_next = post_cnt_inc;
               if (post_cnt_inc == post_len_reg) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (!sample_en) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_reg         <= IDLE;
         sample_en_reg     <= 1'b0;
         pos_reg           <= '0;
         post_len_reg      <= '0;
         last_cnt_reg      <= '0;
         pre_cnt_reg       <= '0;
         post_cnt_reg      <= '0;
         trig_valid_reg    <= 1'b0;
         trig_index_reg    <= '0;
         capture_valid_reg <= 1'b0;
         capture_data_reg  <= '0;
      end else begin
         state_reg         <= state_next;
         sample_en_reg     <= sample_en;
         pos_reg           <= pos_next;
         post_len_reg      <= post_len_next;
         last_cnt_reg      <= last_cnt_next;
         pre_cnt_reg       <= pre_cnt_next;
         post_cnt_reg      <= post_cnt_next;
         trig_valid_reg    <= trig_valid_next;
         trig_index_reg    <= trig_index_next;
         capture_valid_reg <= fwd;
         if (fwd) begin
            capture_data_reg <= sample_data;
         end
      end
   end

   assign capture_valid   = capture_valid_reg;
   assign capture_data    = capture_data_reg;
   assign capture_done    = (state_reg == DONE);
   assign sample_last_cnt = last_cnt_reg;
   assign trig_valid      = trig_valid_reg;
   assign trig_index      = trig_index_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized scoreboard bench for capture_ctrl; expected samples come from a window-arithmetic model.
module tb_capture_ctrl;

   logic        core_clk = 1'b0;
   logic        core_rst;
   logic        sample_en;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        trigger_hit;
   logic [31:0] sample_depth;
   logic [31:0] trigger_pos;
   logic        capture_valid;
   logic [15:0] capture_data;
   logic        capture_done;
   logic [31:0] sample_last_cnt;
   logic        trig_valid;
   logic [31:0] trig_index;

   logic [15:0] exp_q[$];
   logic [15:0] exp_front;
   int          checks = 0;
   int          errors = 0;
   int          pulse_cnt = 0;

   capture_ctrl dut (
      .core_clk        (core_clk),
      .core_rst        (core_rst),
      .sample_en       (sample_en),
      .sample_valid    (sample_valid),
      .sample_data     (sample_data),
      .trigger_hit     (trigger_hit),
      .sample_depth    (sample_depth),
      .trigger_pos     (trigger_pos),
      .capture_valid   (capture_valid),
      .capture_data    (capture_data),
      .capture_done    (capture_done),
      .sample_last_cnt (sample_last_cnt),
      .trig_valid      (trig_valid),
      .trig_index      (trig_index)
   );

   always #5 core_clk = ~core_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest sample the model expects to be forwarded.
   always @(negedge core_clk) begin
      if (capture_valid === 1'b1) begin
         pulse_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual=%0h required=no_write", capture_data);
         end else begin
            exp_front = exp_q.pop_front();
            if (capture_data !== exp_front) begin
               errors++;
               $display("FAIL capture_data actual=%0h required=%0h", capture_data, exp_front);
            end
         end
      end
   end

   // One capture. The model sees the capture as a window: the first cpos accepted samples are
   // pre-trigger, the first trigger after that opens a post window of depth-cpos samples
   // (trigger included), and sample n lands at ring index n mod depth.
   task automatic run_capture(input int depth, input int pos, input int trig_at,
                              input int abort_at, input int vprob);
      int cpos, n_fwd, s, post, exp_ti, start_pulses, cyc;
      bit trig_seen, finished, aborted, v, tr;
      cpos = (pos >= depth) ? depth - 1 : pos;
      n_fwd = 0; s = 0; post = 0; exp_ti = 0; cyc = 0;
      trig_seen = 0; finished = 0; aborted = 0;
      @(negedge core_clk);
      start_pulses = pulse_cnt;
      sample_depth = depth;
      trigger_pos  = pos;
      sample_en    = 1'b1;
      sample_valid = 1'b1;
      trigger_hit  = 1'b1;
      sample_data  = 16'($urandom);
      while (!finished && !aborted && cyc < 500) begin
         @(negedge core_clk);
         cyc++;
         v = ($urandom_range(99) < vprob);
         sample_valid = v;
         sample_data  = 16'($urandom);
         if (v) begin
            s++;
            tr = (s == trig_at) || (n_fwd < cpos && $urandom_range(3) == 0);
            trigger_hit = tr;
            if (s == abort_at) begin
               sample_en   = 1'b0;
               trigger_hit = 1'b1;
               aborted     = 1;
            end else begin
               exp_q.push_back(sample_data);
               if (!trig_seen && n_fwd >= cpos && tr) begin
                  trig_seen = 1;
                  exp_ti    = n_fwd % depth;
                  post      = 1;
               end else if (trig_seen) begin
                  post++;
               end
               n_fwd++;
               if (trig_seen && post == depth - cpos) finished = 1;
            end
         end else begin
            trigger_hit = 1'($urandom_range(1));
         end
      end
      if (!finished && !aborted) begin
         checks++;
         errors++;
         $display("FAIL capture_timeout actual=%0d required=%0d", cyc, 500);
      end
      @(negedge core_clk);
      check("done_level", 32'(capture_done), 32'd1);
      check("trig_valid", 32'(trig_valid), 32'(trig_seen));
      if (trig_seen) check("trig_index", trig_index, 32'(exp_ti));
      check("sample_last_cnt", sample_last_cnt, 32'(depth - 1));
      sample_valid = 1'b1;
      trigger_hit  = 1'b1;
      sample_data  = 16'($urandom);
      @(negedge core_clk);
      check("done_hold", 32'(capture_done), aborted ? 32'd0 : 32'd1);
      sample_en    = 1'b0;
      sample_valid = 1'b0;
      trigger_hit  = 1'b0;
      @(negedge core_clk);
      check("done_clear", 32'(capture_done), 32'd0);
      check("write_count", 32'(pulse_cnt - start_pulses), 32'(n_fwd));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      $display("capture depth=%0d pos=%0d trig_at=%0d abort_at=%0d writes=%0d trig_index=%0d",
               depth, pos, trig_at, abort_at, n_fwd, exp_ti);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(capture_valid), 32'd0);
      check({tag, "_data"}, 32'(capture_data), 32'd0);
      check({tag, "_done"}, 32'(capture_done), 32'd0);
      check({tag, "_last"}, sample_last_cnt, 32'd0);
      check({tag, "_tvalid"}, 32'(trig_valid), 32'd0);
      check({tag, "_tindex"}, trig_index, 32'd0);
   endtask

   task automatic run_reset_mid();
      @(negedge core_clk);
      sample_depth = 8;
      trigger_pos  = 0;
      sample_en    = 1'b1;
      sample_valid = 1'b0;
      trigger_hit  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge core_clk);
         sample_valid = 1'b1;
         trigger_hit  = (i == 0);
         sample_data  = 16'($urandom);
         exp_q.push_back(sample_data);
      end
      @(negedge core_clk);
      sample_valid = 1'b0;
      trigger_hit  = 1'b0;
      sample_en    = 1'b0;
      core_rst     = 1'b1;
      @(negedge core_clk);
      core_rst = 1'b0;
      check_all_zero("mid_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge core_clk);
         check("reset_no_done", 32'(capture_done), 32'd0);
      end
      check("reset_queue", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      $display("reset during post-trigger capture");
   endtask

   initial begin
      int depth, pos, cpos, trig_at, abort_at;
      core_rst     = 1'b1;
      sample_en    = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      trigger_hit  = 1'b0;
      sample_depth = 32'd8;
      trigger_pos  = 32'd2;
      repeat (3) @(negedge core_clk);
      check_all_zero("reset");
      core_rst = 1'b0;

      run_capture(8, 2, 5, 0, 100);
      run_capture(4, 1, 7, 0, 100);
      run_capture(1, 0, 1, 0, 100);
      run_capture(8, 2, 5, 5, 100);
      run_capture(4, 10, 4, 0, 100);
      run_reset_mid();

      for (int n = 0; n < 20; n++) begin
         depth    = $urandom_range(12, 1);
         pos      = $urandom_range(15, 0);
         cpos     = (pos >= depth) ? depth - 1 : pos;
         trig_at  = cpos + 1 + $urandom_range(6, 0);
         abort_at = ($urandom_range(3) == 0) ? $urandom_range(trig_at + depth, 1) : 0;
         run_capture(depth, pos, trig_at, abort_at, $urandom_range(100, 40));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
